wptr_full_ctrl: RTL and testbench

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/wptr_full_ctrl_if.sv | 26 ++
 rtl/wptr_full_ctrl.sv | 71 +++++++
 tb/tb_wptr_full_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wptr_full_ctrl_if.sv
// Producer-side bundle of the async FIFO write controller: write request,
// synchronized read pointer, memory write port and write-side status flags.
interface wptr_full_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  winc;
  logic                  wovf_clr;
  logic [ADDR_WIDTH:0]   rptr_gray_sync;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  wfull;
  logic                  walmost_full;
  logic                  woverflow;
  logic [ADDR_WIDTH:0]   wlevel;

  modport master (
    output winc, wovf_clr, rptr_gray_sync,
    input  wen, waddr, wptr_gray, wfull, walmost_full, woverflow, wlevel
  );

  modport slave (
    input  winc, wovf_clr, rptr_gray_sync,
    output wen, waddr, wptr_gray, wfull, walmost_full, woverflow, wlevel
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and flag logic of an async FIFO: binary/Gray write
// pointer, registered full/almost-full/level against the synchronized read pointer.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic           wclk,
  input  logic           wrst,
  wptr_full_ctrl_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_T = AFULL_THRESH[PW-1:0];

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q, wovf_d;

  logic          wen;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] rgray_full;

  always_comb begin
    wen     = bus.winc & ~wfull_q;
    wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};
    wgray_d = (wbin_d >> 1) ^ wbin_d;

    rbin_s = '0;
    for (int i = 0; i < PW; i++) rbin_s[i] = ^(bus.rptr_gray_sync >> i);

    // Full when the next write pointer equals the read pointer one lap ahead.
    rgray_full = {~bus.rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                  bus.rptr_gray_sync[ADDR_WIDTH-2:0]};
    wfull_d    = (wgray_d == rgray_full);

    wlevel_d = wbin_d - rbin_s;
    wafull_d = (wlevel_d >= AFULL_T);

    wovf_d = wovf_q;
    if (bus.winc & wfull_q) wovf_d = 1'b1;
    else if (bus.wovf_clr)  wovf_d = 1'b0;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.wen          = wen;
  assign bus.waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wptr_gray    = wgray_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = wafull_q;
  assign bus.woverflow    = wovf_q;
  assign bus.wlevel       = wlevel_q;
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed and random checks of the async FIFO write-side pointer/flag block.
module tb_wptr_full_ctrl;
  logic wclk = 1'b0;
  logic wrst;

  wptr_full_ctrl_if #(.ADDR_WIDTH(4)) bus ();

  wptr_full_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(14)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".wptr_gray"}, 32'(bus.wptr_gray), 0);
    chk({tag, ".waddr"},     32'(bus.waddr), 0);
    chk({tag, ".wfull"},     32'(bus.wfull), 0);
    chk({tag, ".wafull"},    32'(bus.walmost_full), 0);
    chk({tag, ".wovf"},      32'(bus.woverflow), 0);
    chk({tag, ".wlevel"},    32'(bus.wlevel), 0);
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    int wb, rb, mw, mr, lvl;
    logic pfull, povf, acc;
    logic [4:0] pgray;

    // Reset state before any clock edge
    wrst = 1'b1;
    bus.winc = 1'b0;
    bus.wovf_clr = 1'b0;
    bus.rptr_gray_sync = '0;
    #2;
    chk_zero("rst0");
    chk("rst0.wen", 32'(bus.wen), 0);

    // Fill 16 entries against an idle reader
    @(negedge wclk);
    wrst = 1'b0;
    bus.winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("fill%0d.wlevel", i), 32'(bus.wlevel), i);
      chk($sformatf("fill%0d.wafull", i), 32'(bus.walmost_full), (i >= 14) ? 1 : 0);
      chk($sformatf("fill%0d.wfull", i),  32'(bus.wfull), (i == 16) ? 1 : 0);
      chk($sformatf("fill%0d.wgray", i),  32'(bus.wptr_gray), 32'(to_gray(i)));
    end
    chk("fill.wgray16", 32'(bus.wptr_gray), 32'h18);
    chk("fill.waddr16", 32'(bus.waddr), 0);

    // Overflow: write attempt while full
    chk("ovf.wen", 32'(bus.wen), 0);
    tick();
    chk("ovf.set", 32'(bus.woverflow), 1);
    chk("ovf.wgray_hold", 32'(bus.wptr_gray), 32'h18);
    chk("ovf.wlevel", 32'(bus.wlevel), 16);
    bus.winc = 1'b0;
    bus.wovf_clr = 1'b1;
    tick();
    chk("ovf.clr", 32'(bus.woverflow), 0);
    bus.winc = 1'b1;
    tick();
    chk("ovf.set_wins", 32'(bus.woverflow), 1);
    bus.winc = 1'b0;
    tick();
    chk("ovf.clr2", 32'(bus.woverflow), 0);
    bus.wovf_clr = 1'b0;

    // Drain visibility: read pointer advances to 4
    bus.rptr_gray_sync = 5'b00110;
    tick();
    chk("drain.wfull", 32'(bus.wfull), 0);
    chk("drain.wlevel", 32'(bus.wlevel), 12);
    chk("drain.wafull", 32'(bus.walmost_full), 0);
    bus.winc = 1'b1;
    #1;
    chk("drain.wen", 32'(bus.wen), 1);
    tick();
    chk("drain.wlevel13", 32'(bus.wlevel), 13);
    chk("drain.waddr", 32'(bus.waddr), 1);
    chk("drain.wgray", 32'(bus.wptr_gray), 32'h19);

    // Wrap 31 -> 0 with the reader trailing by 10
    wb = 17;
    pgray = bus.wptr_gray;
    for (int i = 0; i < 20; i++) begin
      rb = wb + 1 - 10;
      bus.rptr_gray_sync = to_gray(rb);
      tick();
      wb++;
      chk($sformatf("wrap%0d.wgray", i), 32'(bus.wptr_gray), 32'(to_gray(wb)));
      chk($sformatf("wrap%0d.ham", i), 32'($countones(bus.wptr_gray ^ pgray)), 1);
      chk($sformatf("wrap%0d.wlevel", i), 32'(bus.wlevel), 10);
      if (wb == 32) begin
        chk("wrap.before", 32'(pgray), 32'h10);
        chk("wrap.after", 32'(bus.wptr_gray), 32'h00);
      end
      pgray = bus.wptr_gray;
    end

    // Fill to full, then reset mid-cycle with winc held
    for (int i = 0; i < 6; i++) tick();
    chk("prerst.wfull", 32'(bus.wfull), 1);
    chk("prerst.wlevel", 32'(bus.wlevel), 16);
    #2;
    wrst = 1'b1;
    #1;
    chk_zero("rst1");
    chk("rst1.wen", 32'(bus.wen), 1);

    // Random traffic against an occupancy model
    @(negedge wclk);
    bus.winc = 1'b0;
    bus.rptr_gray_sync = '0;
    wrst = 1'b0;
    mw = 0; mr = 0; pfull = 1'b0; povf = 1'b0; pgray = 5'b0;
    for (int c = 0; c < 400; c++) begin
      bus.winc = ($urandom_range(0, 3) != 0);
      bus.wovf_clr = ($urandom_range(0, 7) == 0);
      if (mr < mw && $urandom_range(0, 2) == 0) mr++;
      bus.rptr_gray_sync = to_gray(mr);
      acc = bus.winc & ~pfull;
      #1;
      chk("rnd.wen", 32'(bus.wen), 32'(acc));
      if (bus.winc & pfull) povf = 1'b1;
      else if (bus.wovf_clr) povf = 1'b0;
      @(posedge wclk);
      #1;
      if (acc) mw++;
      lvl = mw - mr;
      pfull = (lvl == 16);
      chk("rnd.wlevel", 32'(bus.wlevel), lvl);
      chk("rnd.wfull", 32'(bus.wfull), 32'(pfull));
      chk("rnd.wafull", 32'(bus.walmost_full), (lvl >= 14) ? 1 : 0);
      chk("rnd.wovf", 32'(bus.woverflow), 32'(povf));
      chk("rnd.wgray", 32'(bus.wptr_gray), 32'(to_gray(mw)));
      chk("rnd.waddr", 32'(bus.waddr), mw % 16);
      chk("rnd.lvl_max", 32'(bus.wlevel > 16), 0);
      chk("rnd.ham", 32'($countones(bus.wptr_gray ^ pgray) > 1), 0);
      pgray = bus.wptr_gray;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
